// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw button level in, debounced level and event pulses out.
interface button_debouncer_if;
  logic din;
  logic db_level;
  logic db_rise;
  logic db_fall;
  logic long_press;

  modport master (
    output din,
    input  db_level,
    input  db_rise,
    input  db_fall,
    input  long_press
  );

  modport slave (
    input  din,
    output db_level,
    output db_rise,
    output db_fall,
    output long_press
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop sync, 4-state qualify FSM, registered level/edge pulses; latency DEBOUNCE_CYCLES+2.
// Optional long-press pulse compiled in with BUTTON_DEBOUNCER_LONGPRESS_EN; no backpressure (free-running).
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] LONG_CYCLES     = 32'd200000000
) (
  input  logic                clk,
  input  logic                rst_n,
  button_debouncer_if.slave   bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 2..2^24");
  end
  if (LONG_CYCLES < 32'd2) begin : g_bad_long
    $error("LONG_CYCLES out of range 2..2^32-1");
  end

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          s1, s2;
  logic          stable_level;
  logic          db_level_q, db_rise_q, db_fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.din;
      s2 <= s1;
    end
  end

  // Accepted level lives in the state encoding; db_level is its registered copy.
  assign stable_level = (state == STABLE_HI) || (state == WAIT_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE_LO: begin
        if (s2) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pulses coincide with the first cycle db_level shows its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level_q <= 1'b0;
      db_rise_q  <= 1'b0;
      db_fall_q  <= 1'b0;
    end else begin
      db_level_q <= stable_level;
      db_rise_q  <= stable_level & ~db_level_q;
      db_fall_q  <= ~stable_level & db_level_q;
    end
  end

  assign bus.db_level = db_level_q;
  assign bus.db_rise  = db_rise_q;
  assign bus.db_fall  = db_fall_q;

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
  logic [31:0] long_cnt;
  logic        long_pulse;
  logic        rise_evt, fall_evt;

  assign rise_evt = stable_level & ~db_level_q;
  assign fall_evt = ~stable_level & db_level_q;

  // Counter parks at LONG_CYCLES so the pulse fires once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (rise_evt || fall_evt) begin
        long_cnt <= '0;
      end else if (stable_level && (long_cnt != LONG_CYCLES)) begin
        long_cnt   <= long_cnt + 32'd1;
        long_pulse <= (long_cnt == LONG_CYCLES - 32'd1);
      end
    end
  end

  assign bus.long_press = long_pulse;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a new input level (legal range 2 to 2^24).
REQ-002 SHALL have parameter LONG_CYCLES, default 200000000, meaning cycles db_level must stay high after a rise before long_press fires (legal range 2 to 2^32-1).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din  input  1  raw, unsynchronized push-button level.
REQ-006 SHALL have port db_level  output  1  debounced, registered button level.
REQ-007 SHALL have port db_rise  output  1  one-cycle pulse on an accepted 0->1 transition.
REQ-008 SHALL have port db_fall  output  1  one-cycle pulse on an accepted 1->0 transition.
REQ-009 SHALL have port long_press  output  1  one-cycle pulse when a held press reaches LONG_CYCLES.

Function
REQ-010 SHALL pass din through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-011 SHALL implement FSM states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO.
REQ-012 SHALL move STABLE_LO->WAIT_HI (or STABLE_HI->WAIT_LO) on the first edge where s2 differs from db_level, loading the stable counter with 1.
REQ-013 SHALL increment the counter on each WAIT_* edge where s2 still differs, saturating at DEBOUNCE_CYCLES-1, with width $clog2(DEBOUNCE_CYCLES).
REQ-014 SHALL return from WAIT_* to the originating STABLE_* state with the counter cleared on any edge where s2 equals db_level (glitch rejected, no output change).
REQ-015 SHALL update db_level to s2, enter the opposite STABLE_* state and clear the counter on the edge where the counter equals DEBOUNCE_CYCLES-1 and s2 still differs.
REQ-016 SHALL give db_level a latency of exactly DEBOUNCE_CYCLES+2 edges from the first edge at which din is sampled at its new, thereafter-stable value.
REQ-017 SHALL register db_rise and db_fall so that each is high only in the single cycle where db_level first shows its new value; the two pulses are never high together.
REQ-018 SHALL produce no pulse for any din transition shorter than DEBOUNCE_CYCLES cycles at s2, regardless of how many glitches occur.
REQ-019 SHALL keep db_rise and db_fall compatible with a downstream edge-pulser, so they never pulse on two consecutive cycles.

Reset
REQ-020 SHALL, while rst_n is low, force s1, s2, db_level, db_rise, db_fall, long_press, the stable counter and the long-press counter to 0 and the FSM to STABLE_LO.
REQ-021 SHALL act on rst_n asynchronously and abandon any in-progress WAIT_* qualification or long-press count, with no pulse emitted on reset entry or exit.
REQ-022 SHALL, after rst_n deasserts with din held high, assert db_rise once after the normal DEBOUNCE_CYCLES+2 latency.

Configuration
REQ-023 SHALL compile long-press detection in only when macro BUTTON_DEBOUNCER_LONGPRESS_EN is defined.
REQ-024 SHALL, with BUTTON_DEBOUNCER_LONGPRESS_EN defined, clear a 32-bit long counter on db_rise and increment it each cycle in STABLE_HI or WAIT_LO.
REQ-025 SHALL, with the macro defined, pulse long_press for one cycle when the long counter reaches LONG_CYCLES, then hold the counter so long_press fires at most once per press.
REQ-026 SHALL, with the macro defined, clear the long counter on db_fall.
REQ-027 SHALL, without BUTTON_DEBOUNCER_LONGPRESS_EN, keep port long_press present, tie it constant 0 and instantiate no long counter.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-028 SHALL cover a clean press: din 0->1 sampled at edge 10 and held -> db_level=1 and db_rise=1 in the cycle after edge 16 only; db_fall stays 0.
REQ-029 SHALL cover glitch rejection: din high for 3 cycles then low, repeated 5 times -> db_level stays 0 and db_rise, db_fall and long_press are never asserted.
REQ-030 SHALL cover bounce then settle: din toggles every cycle for 8 cycles, then stays high -> exactly one db_rise, occurring 6 edges after the final toggle is sampled.
REQ-031 SHALL cover release: from db_level=1, din 1->0 held -> db_fall one cycle, db_level=0 after 6 edges; a 2-cycle high glitch during WAIT_LO leaves db_level=1 and restarts the count.
REQ-032 SHALL cover long press with the macro defined: hold din high 30 cycles -> exactly one long_press pulse 10 cycles after db_rise; with the macro undefined, long_press stays 0.
REQ-033 SHALL cover reset mid-operation: assert rst_n low during WAIT_HI with counter=2 -> all outputs go 0 immediately; after release with din=1, db_rise occurs 6 edges later.
